// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared op encodings, FSM states and default width for the mul/div unit
package mips_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } md_state_t;

endpackage

// File: rtl/abs_neg.sv
// rtl/abs_neg.sv - conditional two's-complement negate at full width
module abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    localparam logic [W-1:0] ONE = W'(1);

    assign o_val = i_neg ? (~i_val + ONE) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 MULT/MULTU/DIV/DIVU with architectural HI/LO
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_t           r_state;
    md_state_t           w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic                r_busy;
    logic                r_done;
    logic                r_is_div;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic                r_b_zero;
    logic [WIDTH-1:0]    r_opnd;
    logic [2*WIDTH-1:0]  r_prod;

    logic                w_is_signed;
    logic                w_is_div;
    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic [WIDTH:0]      w_mul_sum;
    logic [WIDTH:0]      w_div_shift;
    logic [WIDTH:0]      w_div_diff;
    logic                w_div_ok;
    logic [WIDTH-1:0]    w_div_rem;
    logic [2*WIDTH-1:0]  w_prod_fix;
    logic [WIDTH-1:0]    w_quo_fix;
    logic [WIDTH-1:0]    w_rem_fix;

    assign w_is_signed = (op == MD_MULT) || (op == MD_DIV);
    assign w_is_div    = (op == MD_DIV) || (op == MD_DIVU);

    abs_neg #(.W(WIDTH)) u_abs_a (
        .i_val (a),
        .i_neg (w_is_signed & a[WIDTH-1]),
        .o_val (w_a_mag)
    );

    abs_neg #(.W(WIDTH)) u_abs_b (
        .i_val (b),
        .i_neg (w_is_signed & b[WIDTH-1]),
        .o_val (w_b_mag)
    );

    // Multiply: r_prod holds {partial_hi, multiplier remainder}; shift right one bit per step.
    assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                     + (r_prod[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

    // Divide: r_prod holds {remainder, dividend/quotient}; restoring step per cycle.
    assign w_div_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ok    = ~w_div_diff[WIDTH];
    assign w_div_rem   = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];

    abs_neg #(.W(2*WIDTH)) u_fix_prod (
        .i_val (r_prod),
        .i_neg (r_neg_res),
        .o_val (w_prod_fix)
    );

    // A zero divisor leaves the raw all-ones quotient untouched.
    abs_neg #(.W(WIDTH)) u_fix_quo (
        .i_val (r_prod[WIDTH-1:0]),
        .i_neg (r_neg_res & ~r_b_zero),
        .o_val (w_quo_fix)
    );

    abs_neg #(.W(WIDTH)) u_fix_rem (
        .i_val (r_prod[2*WIDTH-1:WIDTH]),
        .i_neg (r_neg_rem),
        .o_val (w_rem_fix)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = w_is_div ? ST_DIV : ST_MUL;
            ST_MUL,
            ST_DIV:  if (r_cnt == CW'(1)) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
            r_opnd    <= '0;
            r_prod    <= '0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mthi) r_hi <= a;
                    if (mtlo) r_lo <= a;
                    if (start) begin
                        r_is_div  <= w_is_div;
                        r_neg_res <= w_is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_rem <= w_is_signed & a[WIDTH-1];
                        r_b_zero  <= (b == '0);
                        r_opnd    <= w_is_div ? w_b_mag : w_a_mag;
                        r_prod    <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                        r_cnt     <= CW'(WIDTH);
                    end
                end
                ST_MUL: begin
                    r_prod <= {w_mul_sum, r_prod[WIDTH-1:1]};
                    r_cnt  <= r_cnt - CW'(1);
                end
                ST_DIV: begin
                    r_prod <= {w_div_rem, r_prod[WIDTH-2:0], w_div_ok};
                    r_cnt  <= r_cnt - CW'(1);
                end
                ST_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized model-checked bench for muldiv_unit
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [W-1:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0;
    int           m_rem = 0;
    logic         m_done = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void ref_result(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                       output logic [W-1:0] rh, output logic [W-1:0] rl);
        longint       sx, sy, q, r;
        logic [63:0]  p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: p = 64'(sx * sy);
            2'b01: p = {32'b0, x} * {32'b0, y};
            2'b10: begin
                if (y == 0) p = {x, 32'hFFFFFFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) p = {x, 32'hFFFFFFFF};
                else p = {x % y, x / y};
            end
        endcase
        rh = p[63:32];
        rl = p[31:0];
    endfunction

    always @(posedge clk) begin
        m_done = 1'b0;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_hi = m_pend_hi; m_lo = m_pend_lo; m_done = 1'b1;
            end
        end else begin
            if (mthi) m_hi = a;
            if (mtlo) m_lo = a;
            if (start) begin
                ref_result(op, a, b, m_pend_hi, m_pend_lo);
                m_rem = W + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_rem != 0));
            chk("done", 64'(done), 64'(m_done));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit junk, output int busy_cyc, output int done_cnt);
        op = o; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        busy_cyc = 0;
        done_cnt = 0;
        for (int k = 0; k < 38; k++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (junk && k >= 2 && k < 30) begin
                start = 1'($urandom_range(0, 1));
                mthi  = 1'($urandom_range(0, 1));
                mtlo  = 1'($urandom_range(0, 1));
                op    = 2'($urandom_range(0, 3));
                a     = $urandom;
                b     = $urandom;
            end else begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
        end
        step();
    endtask

    int bc, dc;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    initial begin
        step(); step();
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_lo", 64'(lo), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        step();

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, bc, dc);
        chk("multu_hi", 64'(hi), 64'hFFFFFFFE);
        chk("multu_lo", 64'(lo), 64'h00000001);
        chk("multu_busy_cycles", 64'(bc), 64'd33);
        chk("multu_done_pulses", 64'(dc), 64'd1);

        run_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, bc, dc);
        chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
        chk("mult_lo", 64'(lo), 64'hFFFFFFEB);

        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, bc, dc);
        chk("div_lo", 64'(lo), 64'hFFFFFFFD);
        chk("div_hi", 64'(hi), 64'hFFFFFFFF);

        run_op(2'b11, 32'd100, 32'd0, 1'b0, bc, dc);
        chk("divu0_lo", 64'(lo), 64'hFFFFFFFF);
        chk("divu0_hi", 64'(hi), 64'd100);

        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, bc, dc);
        chk("divovf_lo", 64'(lo), 64'h80000000);
        chk("divovf_hi", 64'(hi), 64'h0);

        run_op(2'b10, 32'hFFFFFFF9, 32'd0, 1'b0, bc, dc);
        chk("div0neg_lo", 64'(lo), 64'hFFFFFFFF);
        chk("div0neg_hi", 64'(hi), 64'hFFFFFFF9);

        a = 32'h1234; mthi = 1'b1;
        step();
        mthi = 1'b0;
        @(negedge clk);
        chk("mthi", 64'(hi), 64'h1234);
        step();

        op = 2'b11; a = 32'd10; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        mtlo = 1'b1; start = 1'b1; op = 2'b01; a = 32'hDEAD; b = 32'd5;
        step();
        mtlo = 1'b0; start = 1'b0;
        for (int k = 0; k < 40 && busy; k++) step();
        chk("busy_ignore_lo", 64'(lo), 64'd3);
        chk("busy_ignore_hi", 64'(hi), 64'd1);
        chk("busy_ignore_idle", 64'(busy), 64'h0);

        op = 2'b00; a = 32'd12345; b = 32'd678; start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_hi", 64'(hi), 64'h0);
        chk("abort_lo", 64'(lo), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        dc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("abort_no_done", 64'(dc), 64'd0);
        step();

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom;
                mthi = 1'($urandom_range(0, 1));
                mtlo = 1'($urandom_range(0, 1));
                step();
                mthi = 1'b0; mtlo = 1'b0;
            end
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(ro, ra, rb, ($urandom_range(0, 2) == 0), bc, dc);
            chk("rand_done_pulses", 64'(dc), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath; sits in the execute stage.
- Its `hi`/`lo` outputs feed the writeback result-select mux, alongside the ALU result, memory data and link address, for MFHI/MFLO.
- Executes MULT, MULTU, DIV, DIVU (one radix-2 step per cycle) and single-cycle MTHI/MTLO.
- Asserts `busy` so hazard control stalls MFHI/MFLO and new mul/div ops.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a mul/div; sampled in IDLE only.
- op  input  2  operation, sampled with start: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand / dividend), sampled with start.
- b  input  WIDTH  rt operand (multiplier / divisor), sampled with start.
- mthi  input  1  write `a` into HI this cycle.
- mtlo  input  1  write `a` into LO this cycle.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse in the cycle HI/LO take a new mul/div result.

Behaviour:
- Reset (clk edge with `reset`=1): state IDLE; `hi`=0, `lo`=0, `busy`=0, `done`=0; all working registers cleared.
- Reset mid-operation aborts it; HI/LO are cleared and no `done` is issued.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + `start`:
  - Latch `op` and |a|, |b|. Absolute values apply only for signed ops (MULT/DIV); unsigned ops use the raw values.
  - Record the result sign flags.
  - Load counter = WIDTH and go to MUL or DIV.
- MUL: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator. Counter decrements; at 0, go to FIX.
- DIV: restoring divide, one quotient bit per cycle, into a WIDTH remainder and a WIDTH quotient. At counter 0, go to FIX.
- FIX (1 cycle), for signed ops:
  - Product: two's-complement negate the 2*WIDTH product if the operand signs differ.
  - Quotient: negate if the operand signs differ.
  - Remainder: takes the sign of the dividend.
  - Then write HI/LO, pulse `done`, and return to IDLE.
- Timing: `start` accepted at edge N → `busy`=1 from N+1 through the FIX cycle (WIDTH+1 cycles). HI/LO are updated and `busy`=0 after edge N+WIDTH+2.
- Total latency is WIDTH+2 edges = 34 for WIDTH=32.
- HI/LO hold their previous values during MUL/DIV/FIX. Working registers are separate from HI/LO.
- Divide by zero (b=0), signed or unsigned:
  - Result is the raw restoring output: `lo`=all ones, `hi`=a (original operand).
  - No sign fix; no exception.
- Signed overflow 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0. This falls out of the magnitude path; no special case.
- MTHI/MTLO:
  - Honoured only in IDLE; the write takes effect at the next edge.
  - When asserted together, both write `a`.
  - If MTHI/MTLO and `start` occur in the same IDLE cycle, the MT write lands first and the later mul/div result overwrites it.
- Requests while busy: `start`, `mthi` and `mtlo` are ignored when `busy`=1. The pipeline guarantees stalls; the bench checks the requests are ignored.
- `done` and `busy` are registered outputs.
- Arithmetic: all shifts are logical on magnitudes. Sign fixes use two's complement at full width; no saturation.

Decomposition:
- Shared package `mips_pkg`: op encoding constants MD_MULT/MD_MULTU/MD_DIV/MD_DIVU, FSM state encoding, default WIDTH.
- One natural sub-module: `abs_neg` (conditional two's-complement negate, parameterised width). It is instantiated for operand magnitudes and the FIX-stage result corrections.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 34 edges hi=0xFFFFFFFE, lo=0x00000001; `done` pulses once; `busy` high exactly 33 cycles.
- MULT a=-3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=100.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0x1234 in IDLE → hi=0x1234 next cycle. Then start DIVU 10/3 and pulse MTLO and `start` mid-operation → both ignored; final lo=3, hi=1. Assert `reset` at iteration 10 of a new op → hi=lo=0, `busy`=0, no `done`.
